// File: rtl/dm_store_trace.sv
// Data-memory store tracer: snoops the processor's DM write port, records each
// store with a cycle stamp in a FIFO, then drains it over valid/ready on dump.
module dm_store_trace #(
    parameter int N     = 64,
    parameter int DEPTH = 16,
    parameter int CW    = 32
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       DM_writeEnable,
    input  logic [N-1:0]               DM_addr,
    input  logic [N-1:0]               DM_writeData,
    input  logic                       dump,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [N-1:0]               trace_addr,
    output logic [N-1:0]               trace_data,
    output logic [CW-1:0]              trace_cycle,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                drop_count,
    output logic                       done
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    typedef enum logic [1:0] {S_CAPTURE, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [CW-1:0] cycle;
        logic [N-1:0]  addr;
        logic [N-1:0]  data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     drop_q, drop_d;
    entry_t          last_q, last_d;

    logic   full, empty, push, drop, pop, show;
    entry_t head;

    always_comb begin
        full  = (count_q == CNTW'(DEPTH));
        empty = (count_q == '0);
        head  = mem_q[rd_ptr_q];
        push  = (state_q == S_CAPTURE) && DM_writeEnable && !full;
        drop  = (state_q == S_CAPTURE) && DM_writeEnable && full;
        show  = (state_q == S_DRAIN) && !empty;
        pop   = show && trace_ready;

        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        cyc_d      = cyc_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        last_d     = last_q;

        case (state_q)
            S_CAPTURE: begin
                if (cyc_q != '1) cyc_d = cyc_q + CW'(1);
                if (push) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = count_q + CNTW'(1);
                end
                if (drop) begin
                    overflow_d = 1'b1;
                    if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                end
                // The store sampled alongside dump is already handled above.
                if (dump) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    count_d  = count_q - CNTW'(1);
                    last_d   = head;
                end
                if (empty) state_d = S_DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= S_CAPTURE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cyc_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cyc_q      <= cyc_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            last_q     <= last_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever shown.
    always_ff @(posedge CLOCK_50) begin
        if (push) mem_q[wr_ptr_q] <= '{cycle: cyc_q, addr: DM_addr, data: DM_writeData};
    end

    // Show-ahead head while draining; otherwise hold the last popped entry.
    always_comb begin
        trace_valid = show;
        trace_cycle = show ? head.cycle : last_q.cycle;
        trace_addr  = show ? head.addr  : last_q.addr;
        trace_data  = show ? head.data  : last_q.data;
        count       = count_q;
        overflow    = overflow_q;
        drop_count  = drop_q;
        done        = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_dm_store_trace.sv
// Directed bench for dm_store_trace: capture, overflow, backpressure,
// store-with-dump, empty dump, and asynchronous reset mid-drain.
module tb_dm_store_trace;

    localparam int N = 64, DEPTH = 16, CW = 32;

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b1;
    logic          DM_writeEnable = 1'b0;
    logic [N-1:0]  DM_addr = '0;
    logic [N-1:0]  DM_writeData = '0;
    logic          dump = 1'b0;
    logic          trace_valid;
    logic          trace_ready = 1'b0;
    logic [N-1:0]  trace_addr;
    logic [N-1:0]  trace_data;
    logic [CW-1:0] trace_cycle;
    logic [4:0]    count;
    logic          overflow;
    logic [15:0]   drop_count;
    logic          done;

    int checks = 0;
    int failures = 0;

    dm_store_trace #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .DM_writeEnable(DM_writeEnable),
        .DM_addr(DM_addr), .DM_writeData(DM_writeData), .dump(dump),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_addr(trace_addr), .trace_data(trace_data), .trace_cycle(trace_cycle),
        .count(count), .overflow(overflow), .drop_count(drop_count), .done(done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are then sampled 1 time unit later.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        DM_writeEnable = 1'b0;
        dump = 1'b0;
        trace_ready = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic store(input logic [63:0] a, input logic [63:0] d);
        DM_writeEnable = 1'b1;
        DM_addr = a;
        DM_writeData = d;
        tick();
        DM_writeEnable = 1'b0;
    endtask

    task automatic head(input string tag, input logic [63:0] c, input logic [63:0] a,
                        input logic [63:0] d);
        chk({tag, "_valid"}, trace_valid, 1'b1);
        chk({tag, "_cycle"}, trace_cycle, c);
        chk({tag, "_addr"}, trace_addr, a);
        chk({tag, "_data"}, trace_data, d);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", trace_valid, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_drop", drop_count, 0);
        chk("rst_addr", trace_addr, 0);
        chk("rst_cycle", trace_cycle, 0);

        // Basic capture/drain: stores at stamps 3 and 7, dump at stamp 10
        tick(3);
        store(64'h10, 64'hA);
        tick(3);
        store(64'h18, 64'hB);
        tick(2);
        chk("cap_valid", trace_valid, 1'b0);
        dump = 1'b1;
        tick();
        dump = 1'b0;
        chk("b_count2", count, 2);
        head("b_h0", 3, 64'h10, 64'hA);
        trace_ready = 1'b1;
        tick();
        chk("b_count1", count, 1);
        head("b_h1", 7, 64'h18, 64'hB);
        tick();
        chk("b_count0", count, 0);
        chk("b_valid0", trace_valid, 1'b0);
        chk("b_hold_cycle", trace_cycle, 7);
        chk("b_done_early", done, 1'b0);
        tick();
        chk("b_done", done, 1'b1);

        // Overflow: 20 back-to-back stores into a 16-deep FIFO
        do_reset();
        DM_writeEnable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            DM_addr = 64'(i * 8);
            DM_writeData = 64'(i);
            tick();
        end
        DM_writeEnable = 1'b0;
        dump = 1'b1;
        tick();
        dump = 1'b0;
        chk("o_count", count, 16);
        chk("o_ovf", overflow, 1'b1);
        chk("o_drop", drop_count, 4);
        trace_ready = 1'b1;
        DM_writeEnable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            head($sformatf("o_h%0d", i), i, 64'(i * 8), 64'(i));
            tick();
        end
        DM_writeEnable = 1'b0;
        chk("o_count_end", count, 0);
        chk("o_drop_end", drop_count, 4);
        tick();
        chk("o_done", done, 1'b1);

        // Store with dump on the same edge, then backpressure 0,1,0,0,1,1
        do_reset();
        store(64'h20, 64'h1);
        store(64'h28, 64'h2);
        dump = 1'b1;
        store(64'h40, 64'h5);
        dump = 1'b0;
        chk("s_count3", count, 3);
        DM_writeEnable = 1'b1;
        DM_addr = 64'h50;
        DM_writeData = 64'h6;
        trace_ready = 1'b0;
        tick();
        DM_writeEnable = 1'b0;
        chk("s_after_store", count, 3);
        head("s_stall0", 0, 64'h20, 64'h1);
        trace_ready = 1'b1;
        tick();
        chk("s_count2", count, 2);
        head("s_h1", 1, 64'h28, 64'h2);
        trace_ready = 1'b0;
        tick(2);
        chk("s_stall_count", count, 2);
        head("s_stall1", 1, 64'h28, 64'h2);
        trace_ready = 1'b1;
        tick();
        chk("s_count1", count, 1);
        head("s_h2", 2, 64'h40, 64'h5);
        tick();
        chk("s_count0", count, 0);
        chk("s_valid0", trace_valid, 1'b0);
        tick();
        chk("s_done", done, 1'b1);

        // Empty dump and DONE stickiness
        do_reset();
        trace_ready = 1'b1;
        tick();
        dump = 1'b1;
        tick();
        dump = 1'b0;
        chk("e_valid_a", trace_valid, 1'b0);
        chk("e_done_a", done, 1'b0);
        tick();
        chk("e_valid_b", trace_valid, 1'b0);
        chk("e_done_b", done, 1'b1);
        dump = 1'b1;
        tick(2);
        DM_writeEnable = 1'b1;
        tick();
        DM_writeEnable = 1'b0;
        dump = 1'b0;
        chk("e_done_sticky", done, 1'b1);
        chk("e_count", count, 0);

        // Reset mid-drain with 5 entries pending and overflow set
        do_reset();
        DM_writeEnable = 1'b1;
        for (int i = 0; i < 18; i++) begin
            DM_addr = 64'(i);
            DM_writeData = 64'(i);
            tick();
        end
        DM_writeEnable = 1'b0;
        dump = 1'b1;
        tick();
        dump = 1'b0;
        trace_ready = 1'b1;
        tick(11);
        trace_ready = 1'b0;
        chk("r_pending", count, 5);
        chk("r_ovf_pre", overflow, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("r_valid", trace_valid, 1'b0);
        chk("r_count", count, 0);
        chk("r_done", done, 1'b0);
        chk("r_ovf", overflow, 1'b0);
        chk("r_drop", drop_count, 0);
        tick();
        reset = 1'b0;
        store(64'h77, 64'h9);
        dump = 1'b1;
        tick();
        dump = 1'b0;
        chk("r_count_new", count, 1);
        head("r_h0", 0, 64'h77, 64'h9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
